// File: rtl/zap_mult_pkg.sv
// Shared definitions for the ZAP sequential multiply-accumulate unit.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package zap_mult_pkg;

    localparam int CHUNK = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of partial-product cycles for a given operand width.
    function automatic int calc_p(input int width);
        return (width / CHUNK) * (width / CHUNK);
    endfunction

endpackage

// File: rtl/zap_mult17x17.sv
// Shared 17x17 signed leaf multiplier producing a full 34-bit product.
// Latency: combinational.
// Backpressure: none; the output follows the inputs.
module zap_mult17x17
    import zap_mult_pkg::*;
(
    input  logic signed [CHUNK:0]     a,
    input  logic signed [CHUNK:0]     b,
    output logic signed [2*CHUNK+1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/zap_mult_seq.sv
// Multi-cycle signed/unsigned MAC: one 17x17 partial product per cycle, shifted into a 2*WIDTH accumulator.
// Latency: o_done pulses (WIDTH/16)^2 + 1 cycles after the start cycle; one operation per P+2 cycles.
// Backpressure: i_start is only sampled in IDLE; starts while busy are dropped, i_clear aborts at any time.
module zap_mult_seq
    import zap_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_start,
    input  logic               i_signed,
    input  logic               i_acc_en,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [2*WIDTH-1:0] i_acc,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_result,
    output logic               o_n,
    output logic               o_z
);

    localparam int N  = WIDTH / CHUNK;
    localparam int P  = calc_p(WIDTH);
    localparam int W2 = 2 * WIDTH;
    localparam int IW = $clog2(P + 1);

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              sgn_q;
    logic [W2-1:0]     acc;
    logic [IW-1:0]     idx;
    logic [W2-1:0]     result_q;
    logic              busy_q;
    logic              done_q;

    int                ci;
    int                cj;
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic signed [CHUNK:0]     a_ext;
    logic signed [CHUNK:0]     b_ext;
    logic signed [2*CHUNK+1:0] pp;
    logic [W2-1:0]     pp_sh;
    logic [W2-1:0]     acc_nxt;

    // idx walks a's chunks fastest: i = idx mod N, j = idx / N.
    assign ci = int'(idx) % N;
    assign cj = int'(idx) / N;

    assign a_chunk = a_q[CHUNK*ci +: CHUNK];
    assign b_chunk = b_q[CHUNK*cj +: CHUNK];

    // Only the top chunk of a signed operand carries the sign; lower chunks are magnitudes.
    assign a_ext = {(sgn_q && (ci == N - 1)) & a_chunk[CHUNK-1], a_chunk};
    assign b_ext = {(sgn_q && (cj == N - 1)) & b_chunk[CHUNK-1], b_chunk};

    zap_mult17x17 u_leaf (
        .a (a_ext),
        .b (b_ext),
        .p (pp)
    );

    assign pp_sh   = W2'(pp) << (CHUNK * (ci + cj));
    assign acc_nxt = acc + pp_sh;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            acc      <= '0;
            idx      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (i_clear) begin
            state  <= ST_IDLE;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (i_start) begin
                        a_q    <= i_a;
                        b_q    <= i_b;
                        sgn_q  <= i_signed;
                        acc    <= i_acc_en ? i_acc : '0;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc <= acc_nxt;
                    idx <= idx + 1'b1;
                    if (idx == IW'(P - 1)) begin
                        result_q <= acc_nxt;
                        done_q   <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_result = result_q;
    assign o_n      = result_q[W2-1];
    assign o_z      = (result_q == '0);

endmodule

// File: tb/tb_zap_mult_seq.sv
// Directed bench for zap_mult_seq at WIDTH 16, 32 and 64.
// Table of hand-computed vectors at WIDTH 32 plus handshake, abort and parametrisation sequences.
module tb_zap_mult_seq;

    logic clk;
    logic rst;
    logic clr;

    logic         st16, sg16, ae16;
    logic [15:0]  a16, b16;
    logic [31:0]  acc16, res16;
    logic         busy16, done16, n16, z16;

    logic         st32, sg32, ae32;
    logic [31:0]  a32, b32;
    logic [63:0]  acc32, res32;
    logic         busy32, done32, n32, z32;

    logic         st64, sg64, ae64;
    logic [63:0]  a64, b64;
    logic [127:0] acc64, res64;
    logic         busy64, done64, n64, z64;

    int checks = 0;
    int errors = 0;

    zap_mult_seq #(.WIDTH(16)) u16 (
        .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_start(st16), .i_signed(sg16),
        .i_acc_en(ae16), .i_a(a16), .i_b(b16), .i_acc(acc16),
        .o_busy(busy16), .o_done(done16), .o_result(res16), .o_n(n16), .o_z(z16)
    );

    zap_mult_seq #(.WIDTH(32)) u32 (
        .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_start(st32), .i_signed(sg32),
        .i_acc_en(ae32), .i_a(a32), .i_b(b32), .i_acc(acc32),
        .o_busy(busy32), .o_done(done32), .o_result(res32), .o_n(n32), .o_z(z32)
    );

    zap_mult_seq #(.WIDTH(64)) u64 (
        .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_start(st64), .i_signed(sg64),
        .i_acc_en(ae64), .i_a(a64), .i_b(b64), .i_acc(acc64),
        .o_busy(busy64), .o_done(done64), .o_result(res64), .o_n(n64), .o_z(z64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic        ae;
        logic [63:0] acc;
        logic [63:0] res;
        logic        n;
        logic        z;
    } vec_t;

    localparam int NV = 10;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] model64(input logic [63:0] a, input logic [63:0] b,
                                             input logic sg, input logic ae, input logic [127:0] acc);
        logic [127:0] ea;
        logic [127:0] eb;
        ea = sg ? {{64{a[63]}}, a} : {64'b0, a};
        eb = sg ? {{64{b[63]}}, b} : {64'b0, b};
        return ea * eb + (ae ? acc : 128'b0);
    endfunction

    // Starts one operation on the selected instance from a negedge and waits for its done pulse.
    task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b,
                          input logic sg, input logic ae, input logic [127:0] acc,
                          output int dc, output logic [127:0] res, output logic n, output logic z);
        dc = -1; res = '0; n = 1'b0; z = 1'b0;
        case (w)
            16: begin a16 = a[15:0]; b16 = b[15:0]; sg16 = sg; ae16 = ae; acc16 = acc[31:0]; st16 = 1'b1; end
            32: begin a32 = a[31:0]; b32 = b[31:0]; sg32 = sg; ae32 = ae; acc32 = acc[63:0]; st32 = 1'b1; end
            default: begin a64 = a; b64 = b; sg64 = sg; ae64 = ae; acc64 = acc; st64 = 1'b1; end
        endcase
        for (int c = 1; c <= 40 && dc < 0; c++) begin
            @(negedge clk);
            st16 = 1'b0; st32 = 1'b0; st64 = 1'b0;
            case (w)
                16: if (done16) begin dc = c; res = {96'b0, res16}; n = n16; z = z16; end
                32: if (done32) begin dc = c; res = {64'b0, res32}; n = n32; z = z32; end
                default: if (done64) begin dc = c; res = res64; n = n64; z = z64; end
            endcase
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int           dc, dcnt, d1, d2;
        logic [127:0] res, exp;
        logic         n, z, busy1, busy4, busy6;
        logic [63:0]  r1, r2, res4;
        logic [63:0]  ra, rb;
        logic [127:0] racc;

        vt[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'h0, 64'hFFFFFFFE00000001, 1'b1, 1'b0};
        vt[1] = '{32'h80000000, 32'h80000000, 1'b1, 1'b0, 64'h0, 64'h4000000000000000, 1'b0, 1'b0};
        vt[2] = '{32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b0, 64'h0, 64'hFFFFFFFFFFFFFFFE, 1'b1, 1'b0};
        vt[3] = '{32'h00000003, 32'h00000005, 1'b0, 1'b1, 64'h10, 64'h1F, 1'b0, 1'b0};
        vt[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1, 64'h1, 64'h0, 1'b0, 1'b1};
        vt[5] = '{32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b0, 64'h0, 64'h00000001FFFFFFFE, 1'b0, 1'b0};
        vt[6] = '{32'h00010000, 32'h00010000, 1'b0, 1'b0, 64'h1234, 64'h0000000100000000, 1'b0, 1'b0};
        vt[7] = '{32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b0, 64'h0, 64'hFFFFFFFFEDCBA988, 1'b1, 1'b0};
        vt[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 64'h00000001FFFFFFFF, 64'h0, 1'b0, 1'b1};
        vt[9] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 64'h0, 64'hC000000080000000, 1'b1, 1'b0};

        rst = 1'b0; clr = 1'b0;
        st16 = 0; sg16 = 0; ae16 = 0; a16 = '0; b16 = '0; acc16 = '0;
        st32 = 0; sg32 = 0; ae32 = 0; a32 = '0; b32 = '0; acc32 = '0;
        st64 = 0; sg64 = 0; ae64 = 0; a64 = '0; b64 = '0; acc64 = '0;

        #2 rst = 1'b1;
        #1;
        chk("reset busy", busy32, 0);
        chk("reset done", done32, 0);
        chk("reset result", res32, 0);
        chk("reset n", n32, 0);
        chk("reset z", z32, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op(32, {32'b0, vt[i].a}, {32'b0, vt[i].b}, vt[i].sg, vt[i].ae, {64'b0, vt[i].acc}, dc, res, n, z);
            chk($sformatf("v%0d latency", i), dc, 5);
            chk($sformatf("v%0d result", i), res, {64'b0, vt[i].res});
            chk($sformatf("v%0d n", i), n, vt[i].n);
            chk($sformatf("v%0d z", i), z, vt[i].z);
        end

        // Starts during MUL (cycle 2) and DONE (cycle 5) are dropped; cycle 6 is accepted.
        a32 = 32'd3; b32 = 32'd5; sg32 = 0; ae32 = 0; acc32 = '0; st32 = 1'b1;
        dcnt = 0; d1 = -1; d2 = -1; r1 = '0; r2 = '0; busy1 = 0; busy6 = 1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (done32) begin
                dcnt++;
                if (d1 < 0) begin d1 = c; r1 = res32; end
                else begin d2 = c; r2 = res32; end
            end
            if (c == 1) busy1 = busy32;
            if (c == 6) busy6 = busy32;
            st32 = (c == 2 || c == 5 || c == 6);
            if (st32) begin a32 = 32'd7; b32 = 32'd9; end
        end
        st32 = 1'b0;
        chk("busy in MUL", busy1, 1);
        chk("busy after DONE", busy6, 0);
        chk("busy done count", dcnt, 2);
        chk("busy first done cycle", d1, 5);
        chk("busy first result", r1, 64'd15);
        chk("busy second done cycle", d2, 11);
        chk("busy second result", r2, 64'd63);

        // Clear during MUL: back to IDLE, no done, previous result retained.
        a32 = 32'd2; b32 = 32'd2; st32 = 1'b1;
        dcnt = 0; busy4 = 1; res4 = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done32) dcnt++;
            if (c == 4) begin busy4 = busy32; res4 = res32; end
            st32 = 1'b0;
            clr = (c == 3);
        end
        chk("clear busy", busy4, 0);
        chk("clear result kept", res4, 64'd63);
        chk("clear no done", dcnt, 0);

        // Clear wins over start in IDLE.
        clr = 1'b1; st32 = 1'b1; a32 = 32'd4; b32 = 32'd4;
        @(negedge clk);
        clr = 1'b0; st32 = 1'b0;
        chk("clear priority busy", busy32, 0);
        chk("clear priority result", res32, 64'd63);

        // Asynchronous reset mid-operation.
        a32 = 32'd5; b32 = 32'd5; st32 = 1'b1;
        @(negedge clk);
        st32 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset busy", busy32, 0);
        chk("midreset done", done32, 0);
        chk("midreset result", res32, 0);
        chk("midreset n", n32, 0);
        chk("midreset z", z32, 1);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (done32) dcnt++;
        end
        chk("midreset no done", dcnt, 0);

        run_op(16, 64'h8000, 64'h8000, 1'b1, 1'b0, '0, dc, res, n, z);
        chk("w16 s latency", dc, 2);
        chk("w16 s result", res, 128'h40000000);
        run_op(16, 64'hFFFF, 64'hFFFF, 1'b0, 1'b0, '0, dc, res, n, z);
        chk("w16 u result", res, 128'hFFFE0001);
        chk("w16 u n", n, 1);
        run_op(16, 64'hFFFF, 64'h0003, 1'b1, 1'b1, 128'h5, dc, res, n, z);
        chk("w16 mac result", res, 128'h2);

        run_op(64, 64'h8000000000000000, 64'h8000000000000000, 1'b1, 1'b0, '0, dc, res, n, z);
        chk("w64 min latency", dc, 17);
        chk("w64 min result", res, 128'h40000000000000000000000000000000);
        for (int i = 0; i < 6; i++) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            racc = {$urandom, $urandom, $urandom, $urandom};
            exp  = model64(ra, rb, i[0], i[1], racc);
            run_op(64, ra, rb, i[0], i[1], racc, dc, res, n, z);
            chk($sformatf("w64 r%0d latency", i), dc, 17);
            chk($sformatf("w64 r%0d result", i), res, exp);
            chk($sformatf("w64 r%0d n", i), n, exp[127]);
            chk($sformatf("w64 r%0d z", i), z, exp == '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zap_mult_seq.md
Name: zap_mult_seq

Overview:
- Parametrised, multi-cycle signed/unsigned multiply-accumulate unit for the ZAP execute path, covering MUL/MLA/UMULL/UMLAL/SMULL/SMLAL.
- Each WIDTH-bit operand is split into 16-bit chunks. The block issues one 17x17 signed partial product per cycle through a single shared leaf multiplier, then shifts and accumulates it into a 2*WIDTH-bit result.
- The block trades latency for area, and adds a start/done handshake, accumulate, flush and flags.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 16 and at least 16.
- N (derived, not overridable), WIDTH/16, number of chunks per operand.
- P (derived), N*N, number of partial-product cycles.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_clear  in  1  synchronous flush; aborts any operation in progress.
- i_start  in  1  request a new operation; sampled only in IDLE.
- i_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- i_acc_en  in  1  1 = add i_acc to the product.
- i_a  in  WIDTH  multiplicand.
- i_b  in  WIDTH  multiplier.
- i_acc  in  2*WIDTH  addend.
- o_busy  out  1  high in LOAD-free states MUL and DONE (not IDLE).
- o_done  out  1  single-cycle pulse; o_result is valid.
- o_result  out  2*WIDTH  product plus addend, modulo 2^(2*WIDTH).
- o_n  out  1  o_result[2*WIDTH-1].
- o_z  out  1  1 when o_result is all zeros.

Behaviour:
- States: IDLE, MUL, DONE.
- Reset (asynchronous):
  - state = IDLE, all registers = 0.
  - o_busy = 0, o_done = 0, o_result = 0, o_n = 0, o_z = 1.
- IDLE with i_start = 1 (and i_clear = 0), on the clock edge:
  - latch i_a, i_b and i_signed;
  - acc <= i_acc_en ? i_acc : 0;
  - idx <= 0; state <= MUL.
- IDLE with i_start = 0: hold state; o_result keeps its last value.
- MUL, on each edge:
  - acc <= acc + (pp(idx) << 16*(i+j)), with i = idx mod N and j = idx / N;
  - idx increments;
  - after the P-th MUL edge, state <= DONE.
- DONE:
  - o_done = 1 for exactly one cycle; o_result = acc; the flags are computed from acc;
  - state <= IDLE on the next edge;
  - o_result holds until the next accepted start.
- Latency: o_done is high in the cycle P+1 edges after the edge that sampled i_start. With WIDTH = 32 this is done in cycle 5 relative to start in cycle 0.
- Back-to-back operation: i_start asserted in the DONE cycle is ignored. The next start can be accepted in the following IDLE cycle, so throughput is one operation per P+2 cycles.
- Partial-product chunk formation:
  - chunk k of an operand is bits [16k+15:16k];
  - it is sign-extended to 17 bits only when i_signed = 1 and k = N-1;
  - otherwise it is zero-extended;
  - pp = 17x17 signed product, sign-extended to 2*WIDTH before the shift;
  - all sums wrap modulo 2^(2*WIDTH).
- i_start while busy (MUL or DONE): ignored; the latched operands are unchanged.
- i_clear:
  - in any state, on the edge: state <= IDLE, idx <= 0, o_done = 0 next cycle;
  - o_result keeps its previous completed value;
  - i_clear has priority over i_start in the same cycle.
- Reset mid-operation: immediate return to reset values; no o_done.
- Operand inputs may change freely after the start edge without affecting the result.

Decomposition:
- Shared package zap_mult_pkg:
  - state encoding constants (IDLE/MUL/DONE);
  - chunk width constant (16);
  - helper function computing P from WIDTH.
- One sub-module, zap_mult17x17: purely combinational 17x17 signed leaf multiplier producing a 34-bit product, instantiated once.

Test Plan:
- Unsigned full-scale: WIDTH = 32, i_signed = 0, a = b = 0xFFFFFFFF, no accumulate -> o_done in cycle 5, o_result = 0xFFFFFFFE00000001, o_n = 1, o_z = 0.
- Signed extremes:
  - a = b = 0x80000000 -> 0x4000000000000000;
  - a = 0xFFFFFFFF, b = 0x00000002 -> 0xFFFFFFFFFFFFFFFE, o_n = 1.
- Accumulate:
  - a = 3, b = 5, i_acc = 0x10, acc_en = 1 -> 0x1F;
  - signed a = -1, b = 1, i_acc = 1 -> 0, o_z = 1.
- Busy ignore: second i_start with different operands in cycles 2 and 5 (DONE) -> first result unchanged, exactly one o_done; the next start is accepted in cycle 6.
- Abort paths:
  - i_clear in cycle 3 -> no o_done, IDLE next cycle, o_result keeps its previous value;
  - i_reset in cycle 2 -> all outputs at reset values asynchronously.
- Parametrisation:
  - WIDTH = 16, signed 0x8000*0x8000 -> 0x40000000 with o_done in cycle 2;
  - WIDTH = 64, random signed/unsigned against a reference model -> done in cycle 17, results match.
